// File: rtl/cdc_result_sink.sv
// Result sink for the clk_2 side of the CDC block: buffers result strobes, counts them per frame,
// and flags completion, overflow and stall. Optional checksum output when CDC_SINK_CHECKSUM_EN is defined.

// Generic FWFT FIFO with synchronous flush.
// Latency: a word pushed at edge N is visible on dout/!empty after edge N.
// Backpressure: push while full is accepted only if a pop happens in the same cycle, else ignored.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] dout
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      cnt <= cnt + 1'b1;
            else if (do_pop && !do_push) cnt <= cnt - 1'b1;
        end
    end
endmodule

// Frame collector: counts accepted results against exp_cnt, times out stalled frames.
// Latency: result visible on rd_* one cycle after out_valid; frame_done one cycle after last result.
// Backpressure: none toward the CDC; results arriving with the buffer full are dropped and flagged.
module cdc_result_sink #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk_2,
    input  logic              rst_n,
    input  logic              out_valid,
    input  logic [DATA_W-1:0] out,
    input  logic              start,
    input  logic [3:0]        exp_cnt,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              frame_done,
    output logic              overflow,
`ifdef CDC_SINK_CHECKSUM_EN
    output logic [11:0]       checksum,
`endif
    output logic              timeout
);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2,
        ERR     = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [4:0]        exp_len;
    logic [4:0]        count;
    logic [4:0]        count_inc;
    logic [TW-1:0]     timer;
    logic              start_ok;
    logic              accept;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W-1:0] fifo_dout;

    assign start_ok  = start && ((state == IDLE) || (state == ERR));
    assign accept    = (state == COLLECT) && out_valid;
    assign pop       = rd_valid && rd_ready;
    assign count_inc = count + 5'd1;

    sync_fifo #(
        .W     (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk_2),
        .arst_n (rst_n),
        .flush  (start_ok),
        .push   (accept),
        .pop    (pop),
        .din    (out),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .dout   (fifo_dout)
    );

    // Stale RAM contents are masked so an empty buffer always presents zero.
    assign rd_valid   = !fifo_empty;
    assign rd_data    = fifo_empty ? '0 : fifo_dout;
    assign frame_done = (state == DONE);
    assign timeout    = (state == ERR);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_ok) state_nxt = COLLECT;
            COLLECT: begin
                if (accept && (count_inc == exp_len))            state_nxt = DONE;
                else if (!out_valid && (timer == TIMER_LAST))    state_nxt = ERR;
            end
            DONE:    state_nxt = IDLE;
            ERR:     if (start_ok) state_nxt = COLLECT;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            exp_len  <= '0;
            count    <= '0;
            timer    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start_ok) begin
                // exp_cnt of zero encodes a 16-result frame.
                exp_len  <= {(exp_cnt == 4'd0), exp_cnt};
                count    <= '0;
                timer    <= '0;
                overflow <= 1'b0;
            end else if (state == COLLECT) begin
                if (accept) begin
                    count <= count_inc;
                    timer <= '0;
                    if (fifo_full && !pop) overflow <= 1'b1;
                end else begin
                    timer <= timer + 1'b1;
                end
            end
        end
    end

`ifdef CDC_SINK_CHECKSUM_EN
    // Dropped words still contribute, so the sum reflects what the CDC delivered.
    always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum + 12'(out);
        end
    end
`endif
endmodule

// File: tb/tb_cdc_result_sink.sv
// Directed self-checking bench for cdc_result_sink; covers checksum when CDC_SINK_CHECKSUM_EN is defined.
module tb_cdc_result_sink;
    logic       clk_2 = 1'b0;
    logic       rst_n;
    logic       out_valid;
    logic [7:0] out;
    logic       start;
    logic [3:0] exp_cnt;
    logic       rd_ready;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       frame_done;
    logic       overflow;
    logic       timeout;
`ifdef CDC_SINK_CHECKSUM_EN
    logic [11:0] checksum;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_2 = ~clk_2;

    cdc_result_sink #(
        .DATA_W      (8),
        .DEPTH       (4),
        .TIMEOUT_CYC (64)
    ) dut (
        .clk_2      (clk_2),
        .rst_n      (rst_n),
        .out_valid  (out_valid),
        .out        (out),
        .start      (start),
        .exp_cnt    (exp_cnt),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .overflow   (overflow),
`ifdef CDC_SINK_CHECKSUM_EN
        .checksum   (checksum),
`endif
        .timeout    (timeout)
    );

    // Inputs change at negedge; outputs are observed at the following negedge.
    task automatic tick();
        @(posedge clk_2);
        @(negedge clk_2);
    endtask

    task automatic do_start(input logic [3:0] n);
        start   = 1'b1;
        exp_cnt = n;
        tick();
        start   = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; out_valid = 1'b0; out = '0; start = 1'b0; exp_cnt = '0; rd_ready = 1'b0;
        #22;
        n_total++;
        if ({rd_valid, rd_data, frame_done, overflow, timeout} !== 12'h000) begin
            $display("FAIL reset_outputs got v=%b d=%h fd=%b ov=%b to=%b exp all 0",
                     rd_valid, rd_data, frame_done, overflow, timeout);
        end else n_pass++;
        @(negedge clk_2);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic_frame();
        logic [7:0] words [3];
        words[0] = 8'h12; words[1] = 8'h34; words[2] = 8'h56;
        do_start(4'd3);
        rd_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            out_valid = 1'b1;
            out       = words[i];
            tick();
            n_total++;
            if (rd_valid !== 1'b1 || rd_data !== words[i]) begin
                $display("FAIL basic_rd%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, words[i]);
            end else n_pass++;
            n_total++;
            if (frame_done !== (i == 2)) begin
                $display("FAIL basic_done%0d got %b exp %b", i, frame_done, (i == 2));
            end else n_pass++;
        end
        out_valid = 1'b0;
        tick();
        n_total++;
        if ({frame_done, rd_valid, overflow, timeout} !== 4'b0000) begin
            $display("FAIL basic_after got fd=%b v=%b ov=%b to=%b exp 0000", frame_done, rd_valid, overflow, timeout);
        end else n_pass++;
    endtask

    task automatic test_overflow();
        do_start(4'd6);
        rd_ready = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            out_valid = 1'b1;
            out       = 8'hA0 + 8'(i);
            tick();
            n_total++;
            if (rd_valid !== 1'b1 || overflow !== (i >= 5)) begin
                $display("FAIL ovf_push%0d got v=%b ov=%b exp v=1 ov=%b", i, rd_valid, overflow, (i >= 5));
            end else n_pass++;
        end
        n_total++;
        if (frame_done !== 1'b1) begin
            $display("FAIL ovf_done got %b exp 1", frame_done);
        end else n_pass++;
        out_valid = 1'b0;
        rd_ready  = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_total++;
            if (rd_valid !== 1'b1 || rd_data !== 8'hA0 + 8'(i)) begin
                $display("FAIL ovf_drain%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, 8'hA0 + 8'(i));
            end else n_pass++;
            tick();
        end
        n_total++;
        if (rd_valid !== 1'b0 || overflow !== 1'b1) begin
            $display("FAIL ovf_empty got v=%b ov=%b exp v=0 ov=1", rd_valid, overflow);
        end else n_pass++;
    endtask

    task automatic test_full_push_pop();
        rd_ready = 1'b0;
        do_start(4'd5);
        n_total++;
        if (overflow !== 1'b0) begin
            $display("FAIL fpp_ovclr got %b exp 0", overflow);
        end else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            out_valid = 1'b1;
            out       = 8'hB0 + 8'(i);
            tick();
        end
        out       = 8'hB5;
        rd_ready  = 1'b1;
        tick();
        n_total++;
        if (overflow !== 1'b0 || frame_done !== 1'b1 || rd_data !== 8'hB2) begin
            $display("FAIL fpp_same got ov=%b fd=%b d=%h exp ov=0 fd=1 d=b2", overflow, frame_done, rd_data);
        end else n_pass++;
        out_valid = 1'b0;
        for (int i = 2; i <= 5; i++) begin
            n_total++;
            if (rd_valid !== 1'b1 || rd_data !== 8'hB0 + 8'(i)) begin
                $display("FAIL fpp_drain%0d got v=%b d=%h exp v=1 d=%h", i, rd_valid, rd_data, 8'hB0 + 8'(i));
            end else n_pass++;
            tick();
        end
        n_total++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL fpp_empty got %b exp 0", rd_valid);
        end else n_pass++;
    endtask

    task automatic test_timeout();
        logic saw_fd;
        saw_fd   = 1'b0;
        rd_ready = 1'b1;
        do_start(4'd2);
        out_valid = 1'b1;
        out       = 8'hC1;
        tick();
        out_valid = 1'b0;
        for (int i = 0; i < 63; i++) begin
            tick();
            if (frame_done) saw_fd = 1'b1;
        end
        n_total++;
        if (timeout !== 1'b0) begin
            $display("FAIL to_early got %b exp 0 after 63 idle cycles", timeout);
        end else n_pass++;
        tick();
        n_total++;
        if (timeout !== 1'b1) begin
            $display("FAIL to_set got %b exp 1 after 64 idle cycles", timeout);
        end else n_pass++;
        tick();
        if (frame_done) saw_fd = 1'b1;
        n_total++;
        if (timeout !== 1'b1 || saw_fd !== 1'b0) begin
            $display("FAIL to_sticky got to=%b saw_fd=%b exp to=1 saw_fd=0", timeout, saw_fd);
        end else n_pass++;
        do_start(4'd2);
        n_total++;
        if (timeout !== 1'b0) begin
            $display("FAIL to_clear got %b exp 0", timeout);
        end else n_pass++;
        out_valid = 1'b1;
        out       = 8'hC2;
        tick();
        out = 8'hC3;
        tick();
        n_total++;
        if (frame_done !== 1'b1) begin
            $display("FAIL to_recover got %b exp 1", frame_done);
        end else n_pass++;
        out_valid = 1'b0;
        tick();
    endtask

    task automatic test_len16_ignores();
        rd_ready  = 1'b0;
        out_valid = 1'b1;
        out       = 8'hD0;
        tick();
        n_total++;
        if (rd_valid !== 1'b0) begin
            $display("FAIL idle_discard got v=%b exp 0", rd_valid);
        end else n_pass++;
        out_valid = 1'b0;
        rd_ready  = 1'b1;
        do_start(4'd0);
        for (int i = 1; i <= 16; i++) begin
            if (i == 9) begin
                out_valid = 1'b0;
                start     = 1'b1;
                exp_cnt   = 4'd1;
                tick();
                start = 1'b0;
            end
            out_valid = 1'b1;
            out       = 8'(i);
            tick();
            n_total++;
            if (frame_done !== (i == 16)) begin
                $display("FAIL len16_res%0d got fd=%b exp %b", i, frame_done, (i == 16));
            end else n_pass++;
        end
        out_valid = 1'b0;
        tick();
    endtask

`ifdef CDC_SINK_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] words [3];
        words[0] = 8'hFF; words[1] = 8'hFF; words[2] = 8'h02;
        rd_ready = 1'b1;
        do_start(4'd3);
        for (int i = 0; i < 3; i++) begin
            out_valid = 1'b1;
            out       = words[i];
            tick();
        end
        out_valid = 1'b0;
        n_total++;
        if (checksum !== 12'h200) begin
            $display("FAIL csum_sum got %h exp 200", checksum);
        end else n_pass++;
        tick();
        n_total++;
        if (checksum !== 12'h200) begin
            $display("FAIL csum_hold got %h exp 200", checksum);
        end else n_pass++;
        do_start(4'd3);
        n_total++;
        if (checksum !== 12'h000) begin
            $display("FAIL csum_clear got %h exp 000", checksum);
        end else n_pass++;
        out_valid = 1'b1;
        out       = 8'h07;
        tick();
        out_valid = 1'b0;
        tick();
    endtask
`endif

    task automatic test_reset_mid();
        logic saw_fd;
        saw_fd = 1'b0;
        if (!timeout && !frame_done) begin
            out_valid = 1'b0;
        end
        rd_ready = 1'b0;
        // Any unfinished frame from the previous task is absorbed by reset below.
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        @(negedge clk_2);
        do_start(4'd8);
        for (int i = 0; i < 5; i++) begin
            out_valid = 1'b1;
            out       = 8'hE0 + 8'(i);
            tick();
        end
        out_valid = 1'b0;
        n_total++;
        if (overflow !== 1'b1 || rd_valid !== 1'b1) begin
            $display("FAIL rmid_pre got ov=%b v=%b exp ov=1 v=1", overflow, rd_valid);
        end else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({rd_valid, rd_data, frame_done, overflow, timeout} !== 12'h000) begin
            $display("FAIL rmid_outputs got v=%b d=%h fd=%b ov=%b to=%b exp all 0",
                     rd_valid, rd_data, frame_done, overflow, timeout);
        end else n_pass++;
`ifdef CDC_SINK_CHECKSUM_EN
        n_total++;
        if (checksum !== 12'h000) begin
            $display("FAIL rmid_csum got %h exp 000", checksum);
        end else n_pass++;
`endif
        @(negedge clk_2);
        rst_n = 1'b1;
        out_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (frame_done) saw_fd = 1'b1;
        end
        out_valid = 1'b0;
        n_total++;
        if (saw_fd !== 1'b0 || rd_valid !== 1'b0) begin
            $display("FAIL rmid_after got saw_fd=%b v=%b exp 0 0", saw_fd, rd_valid);
        end else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_overflow();
        test_full_push_pop();
        test_timeout();
        test_len16_ignores();
`ifdef CDC_SINK_CHECKSUM_EN
        test_checksum();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
